// File: rtl/lc4_decode_stage.sv
// lc4_decode_stage
// Decode / register-read stage of the LC4 pipeline. It holds the 8x16
// architectural register file. It decodes the source-register fields of the
// instruction coming from fetch and detects load-use hazards. It then loads
// the D/X pipeline register that feeds the ALU on the following cycle.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   i_insn, i_pc    instruction word from fetch and its PC
//   i_valid         i_insn is a real instruction
//   i_flush         mispredict from X: squash the instruction in D
//   i_wb_we/rd/data register-file write port (writeback)
//   o_stall         combinational: fetch must hold i_insn/i_pc this cycle
//   o_insn, o_pc    D/X instruction and PC
//   o_r1data/r2data D/X rs and rt operand values (0 when the port is unused)
//   o_valid         D/X slot holds a real instruction
//
// Optional build macro LC4_DECODE_STALL_CNT_EN adds the output o_stall_count.
// It is a 16-bit saturating count of the cycles that were lost to load-use
// stalls.
//
// Handshake: fetch offers i_insn whenever i_valid=1. The instruction counts
// as accepted on a rising edge where o_stall=0. While o_stall=1, fetch must
// present the same i_insn/i_pc again on the next cycle.

module lc4_decode_stage #(
  parameter int          NREGS    = 8,
  parameter logic [15:0] NOP_INSN = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_insn,
  input  logic [15:0] i_pc,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_rd,
  input  logic [15:0] i_wb_data,
  output logic        o_stall,
  output logic [15:0] o_insn,
  output logic [15:0] o_pc,
  output logic [15:0] o_r1data,
  output logic [15:0] o_r2data,
  output logic        o_valid
`ifdef LC4_DECODE_STALL_CNT_EN
  ,
  output logic [15:0] o_stall_count
`endif
);

  logic [15:0] regs [NREGS];

  logic [3:0]  opcode;
  logic [2:0]  rs_idx, rt_idx;
  logic        rs_use, rt_use;
  logic [15:0] rs_val, rt_val;
  logic        dx_is_load;
  logic        hazard;

  assign opcode = i_insn[15:12];

  // Source decode: which register fields the instruction reads
  always_comb begin
    rs_idx = 3'd0;
    rt_idx = 3'd0;
    rs_use = 1'b0;
    rt_use = 1'b0;
    case (opcode)
      4'b0001, 4'b0101: begin        // arith / logic: rt only in register form
        rs_idx = i_insn[8:6];  rs_use = 1'b1;
        rt_idx = i_insn[2:0];  rt_use = ~i_insn[5];
      end
      4'b0010: begin                 // compare: rt only in register form
        rs_idx = i_insn[11:9]; rs_use = 1'b1;
        rt_idx = i_insn[2:0];  rt_use = ~i_insn[8];
      end
      4'b0100, 4'b1100: begin        // JSRR / JMPR only; JSR / JMP read nothing
        rs_idx = i_insn[8:6];  rs_use = ~i_insn[11];
      end
      4'b0110: begin                 // LDR
        rs_idx = i_insn[8:6];  rs_use = 1'b1;
      end
      4'b0111: begin                 // STR: base in rs, stored value in rt
        rs_idx = i_insn[8:6];  rs_use = 1'b1;
        rt_idx = i_insn[11:9]; rt_use = 1'b1;
      end
      4'b1000: begin                 // RTI returns through R7
        rs_idx = 3'd7;         rs_use = 1'b1;
      end
      4'b1010: begin                 // shifts / MOD: rt only for MOD
        rs_idx = i_insn[8:6];  rs_use = 1'b1;
        rt_idx = i_insn[2:0];  rt_use = (i_insn[5:4] == 2'b11);
      end
      4'b1101: begin                 // HICONST keeps the low byte of Rd
        rs_idx = i_insn[11:9]; rs_use = 1'b1;
      end
      default: ;
    endcase
  end

  // Read ports with a same-cycle writeback bypass. Unused ports read 0.
  always_comb begin
    rs_val = 16'h0000;
    rt_val = 16'h0000;
    if (rs_use) rs_val = (i_wb_we && i_wb_rd == rs_idx) ? i_wb_data : regs[rs_idx];
    if (rt_use) rt_val = (i_wb_we && i_wb_rd == rt_idx) ? i_wb_data : regs[rt_idx];
  end

  // Load-use: the LDR now in D/X delivers its data too late for an
  // instruction in D that reads the LDR's destination register.
  assign dx_is_load = o_valid && (o_insn[15:12] == 4'b0110);
  assign hazard     = i_valid && dx_is_load &&
                      ((rs_use && rs_idx == o_insn[11:9]) ||
                       (rt_use && rt_idx == o_insn[11:9]));
  // A flush kills the instruction in D, so nothing is left to hold.
  assign o_stall    = hazard && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
    end else if (i_wb_we) begin
      regs[i_wb_rd] <= i_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_insn   <= NOP_INSN;
      o_pc     <= 16'h0000;
      o_r1data <= 16'h0000;
      o_r2data <= 16'h0000;
      o_valid  <= 1'b0;
    end else if (i_flush || o_stall) begin
      o_insn   <= NOP_INSN;
      o_pc     <= 16'h0000;
      o_r1data <= 16'h0000;
      o_r2data <= 16'h0000;
      o_valid  <= 1'b0;
    end else begin
      o_insn   <= i_valid ? i_insn : NOP_INSN;
      o_pc     <= i_pc;
      o_r1data <= rs_val;
      o_r2data <= rt_val;
      o_valid  <= i_valid;
    end
  end

`ifdef LC4_DECODE_STALL_CNT_EN
  // o_stall is already low under a flush, so it alone qualifies the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stall_count <= 16'h0000;
    end else if (o_stall && o_stall_count != 16'hFFFF) begin
      o_stall_count <= o_stall_count + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/lc4_decode_stage.md
Name: lc4_decode_stage

Overview:
- Decode/register-read stage for the LC4 pipeline, directly upstream of the LC4 ALU.
- Holds the 8x16 architectural register file and decodes source-register fields from the fetched instruction.
- Performs load-use hazard detection and flush handling.
- Registers {insn, pc, r1data, r2data, valid} into the D/X pipeline register that drives the ALU in the next cycle.

Parameters:
- NREGS, 8, number of architectural registers; index width is 3 bits, fixed by the ISA.
- NOP_INSN, 16'h0000, instruction word loaded into the D/X register for a bubble (BRnzp-never, i.e. a NOP).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_insn  in  16  instruction from fetch.
- i_pc  in  16  PC of i_insn.
- i_valid  in  1  i_insn is a real instruction.
- i_flush  in  1  mispredict from X; squash the D-stage instruction.
- i_wb_we  in  1  writeback enable.
- i_wb_rd  in  3  writeback register index.
- i_wb_data  in  16  writeback data.
- o_stall  out  1  combinational; fetch must hold i_insn/i_pc this cycle.
- o_insn  out  16  D/X insn to ALU.
- o_pc  out  16  D/X pc to ALU.
- o_r1data  out  16  D/X rs value to ALU.
- o_r2data  out  16  D/X rt value to ALU.
- o_valid  out  1  D/X slot holds a real instruction.

Behaviour:
- Reset (async, rst_n=0): all 8 registers = 0; o_insn = NOP_INSN; o_pc = 0; o_r1data = o_r2data = 0; o_valid = 0. While rst_n is held low, writeback is ignored.
- Register file: one write port, written at the clock edge when i_wb_we=1. Two combinational read ports (rs, rt).
- Write-to-read bypass: if i_wb_we=1 and i_wb_rd equals the read index, the read returns i_wb_data in the same cycle.
- Source decode (rs index / rt index / uses):
  - 0001 and 0101: rs=I[8:6]; rt=I[2:0] read only when I[5]=0.
  - 0010: rs=I[11:9]; rt=I[2:0] read only when I[8]=0.
  - 0100 with I[11]=0, and 1100 with I[11]=0: rs=I[8:6].
  - 0110: rs=I[8:6].
  - 0111: rs=I[8:6], rt=I[11:9].
  - 1000: rs=R7.
  - 1010: rs=I[8:6]; rt=I[2:0] read only when I[5:4]=11.
  - 1101: rs=I[11:9].
  - All other opcodes read nothing; unused read ports output 0.
- Load-use stall: o_stall=1 when all of the following hold: i_valid=1, o_valid=1, o_insn[15:12]=0110, and o_insn[11:9] equals a used source index of i_insn.
- Priority at the clock edge:
  1. i_flush=1: load bubble (o_valid=0, o_insn=NOP_INSN, data=0); o_stall is forced to 0.
  2. Else o_stall=1: load bubble; the fetch side re-presents the same instruction next cycle.
  3. Else: load {i_insn, i_pc, rs value, rt value, i_valid}. If i_valid=0, o_insn = NOP_INSN.
- Latency: 1 cycle from D-stage inputs to D/X outputs; a stall adds exactly 1 bubble per load-use pair.
- Writing a register in the same cycle it is read for a stalled instruction: the bypass still applies, and the next cycle's read sees the new value from the array.
- Reset mid-operation clears the pipeline register and the register file immediately; no partial write completes.

Optional Feature:
- Macro LC4_DECODE_STALL_CNT_EN.
- Defined: adds output port o_stall_count (16 bits).
  - Resets to 0.
  - Increments on each rising edge where o_stall=1 and i_flush=0.
  - Saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then writeback R3=16'h1234 (i_wb_we=1, rd=3); next cycle present ADD R1,R3,R3 (16'h12C3) valid -> after one edge o_r1data=o_r2data=16'h1234, o_valid=1, o_insn=16'h12C3.
- Same-cycle bypass: i_wb_we=1, rd=2, data=16'hBEEF while presenting STR R2,R2,#0 (16'h7480) -> next cycle o_r1data=o_r2data=16'hBEEF.
- Load-use: LDR R4,R0,#0 (16'h6800) enters D/X; next D insn ADD R5,R4,R1 (16'h1B01) -> o_stall=1 for 1 cycle, bubble (o_valid=0, o_insn=16'h0000); following cycle ADD enters D/X with o_valid=1.
- Flush during a would-be stall: same setup as the load-use case with i_flush=1 -> o_stall=0, D/X gets a bubble; with the macro defined, o_stall_count is unchanged.
- Immediate forms: ADD R1,R2,#-1 (16'h12BF) -> only rs read; o_r2data=0 and no stall even if the previous insn is LDR R1 (16'h6200)... **correction:** R1 here is the destination, not a source, so no stall; a separate case of LDR R7 followed by RTI -> stall, since RTI reads R7.
- Async reset asserted mid-stream (not aligned to clk) -> outputs clear immediately to the reset values; registers read 0 after rst_n deasserts.
